// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode encodings, instruction field widths, the
// decoded-field record, and the immediate-extension rule.
package mips_pkg;

  localparam int INST_W   = 32;
  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNC_W   = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;

  localparam logic [OP_W-1:0] OP_J    = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [SHAMT_W-1:0]  shamt;
    logic [FUNC_W-1:0]   func;
    logic [IMM_W-1:0]    imm16;
    logic [INST_W-1:0]   imm_ext;
    logic [TARGET_W-1:0] target;
  } inst_fields_t;

  // Logical immediates zero-extend, lui shifts into the upper half, the rest sign-extend.
  function automatic logic [INST_W-1:0] extend_imm(input logic [OP_W-1:0] op,
                                                   input logic [IMM_W-1:0] imm);
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: extend_imm = {16'h0000, imm};
      OP_LUI:                   extend_imm = {imm, 16'h0000};
      default:                  extend_imm = {{16{imm[15]}}, imm};
    endcase
  endfunction

  function automatic logic is_jump(input logic [OP_W-1:0] op);
    is_jump = (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/inst_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
// master drives fetch data and decode ready; slave is the queue itself.
interface inst_decode_queue_if #(parameter int PC_W = 32);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_op;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_func;
  logic [15:0]     out_imm16;
  logic [31:0]     out_imm_ext;
  logic [25:0]     out_target;
  logic [PC_W-1:0] out_jaddr;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_func, out_imm16, out_imm_ext, out_target, out_jaddr, out_pc
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rs, out_rt, out_rd, out_shamt,
           out_func, out_imm16, out_imm_ext, out_target, out_jaddr, out_pc
  );

endinterface

// File: rtl/inst_field_split.sv
// Purely combinational split of a MIPS instruction word into its fields,
// including the opcode-dependent immediate extension.
module inst_field_split
  import mips_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output inst_fields_t      fields
);

  // NOTE: every combinational output gets a value on every path, so no latch can form.
  always_comb begin
    fields.op      = inst[31:26];
    fields.rs      = inst[25:21];
    fields.rt      = inst[20:16];
    fields.rd      = inst[15:11];
    fields.shamt   = inst[10:6];
    fields.func    = inst[5:0];
    fields.imm16   = inst[15:0];
    fields.target  = inst[25:0];
    fields.imm_ext = extend_imm(inst[31:26], inst[15:0]);
  end

endmodule

// File: rtl/inst_decode_queue.sv
// Fetch-to-decode instruction FIFO with first-word fall-through: the head entry
// is presented already split into fields, with extended immediate and jump address.
module inst_decode_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  inst_decode_queue_if.slave bus,
  output logic [CNT_W-1:0] count
);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              push;
  logic              pop;
  logic [INST_W-1:0] head_inst;
  logic [PC_W-1:0]   head_pc;
  logic [PC_W-1:0]   pc4;
  logic [PC_W-1:0]   jaddr;
  inst_fields_t      fields;

  // Handshake flags come from the registered count only.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr] <= bus.in_inst;
      pc_mem[wr_ptr]   <= bus.in_pc;
    end
  end

  assign head_inst = bus.out_valid ? inst_mem[rd_ptr] : '0;
  assign head_pc   = bus.out_valid ? pc_mem[rd_ptr]   : '0;

  inst_field_split u_split (
    .inst   (head_inst),
    .fields (fields)
  );

  // Jump keeps the region bits of pc+4 above bit 27 and replaces the rest.
  always_comb begin
    pc4         = head_pc + PC_W'(4);
    jaddr       = pc4;
    jaddr[27:0] = {fields.target, 2'b00};
  end

  assign bus.out_op      = fields.op;
  assign bus.out_rs      = fields.rs;
  assign bus.out_rt      = fields.rt;
  assign bus.out_rd      = fields.rd;
  assign bus.out_shamt   = fields.shamt;
  assign bus.out_func    = fields.func;
  assign bus.out_imm16   = fields.imm16;
  assign bus.out_imm_ext = fields.imm_ext;
  assign bus.out_target  = fields.target;
  assign bus.out_pc      = head_pc;
  assign bus.out_jaddr   = bus.out_valid ? jaddr : '0;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue: a decode vector table plus hand-written
// sequences for fill/wrap, concurrent push/pop, flush priority and async reset.
module tb_inst_decode_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;

  int n_checks = 0;
  int n_errors = 0;

  inst_decode_queue_if #(.PC_W(PC_W)) bus ();

  inst_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [31:0] imm_ext;
    logic [25:0] target;
    logic [31:0] jaddr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_empty(input string tag);
    check({tag, " out_valid"},   64'(bus.out_valid),   64'd0);
    check({tag, " count"},       64'(count),           64'd0);
    check({tag, " in_ready"},    64'(bus.in_ready),    64'd1);
    check({tag, " out_op"},      64'(bus.out_op),      64'd0);
    check({tag, " out_imm_ext"}, 64'(bus.out_imm_ext), 64'd0);
    check({tag, " out_jaddr"},   64'(bus.out_jaddr),   64'd0);
    check({tag, " out_pc"},      64'(bus.out_pc),      64'd0);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    //            inst          pc            op     rs     rt     rd     sh     func   imm_ext       target        jaddr
    vecs[0] = '{32'h2008FFFF, 32'h00400000, 6'h08, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3F, 32'hFFFFFFFF, 26'h008FFFF, 32'h0023FFFC};
    vecs[1] = '{32'h3408FFFF, 32'h00400004, 6'h0D, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3F, 32'h0000FFFF, 26'h008FFFF, 32'h0023FFFC};
    vecs[2] = '{32'h3C081234, 32'h0040000C, 6'h0F, 5'd0, 5'd8,  5'd2,  5'd8,  6'h34, 32'h12340000, 26'h0081234, 32'h002048D0};
    vecs[3] = '{32'h08100004, 32'h00400008, 6'h02, 5'd0, 5'd16, 5'd0,  5'd0,  6'h04, 32'h00000004, 26'h0100004, 32'h00400010};
    vecs[4] = '{32'h0C000001, 32'hF0000000, 6'h03, 5'd0, 5'd0,  5'd0,  5'd0,  6'h01, 32'h00000001, 26'h0000001, 32'hF0000004};
    vecs[5] = '{32'h30088000, 32'h00400010, 6'h0C, 5'd0, 5'd8,  5'd16, 5'd0,  6'h00, 32'h00008000, 26'h0088000, 32'h00220000};
    vecs[6] = '{32'h38088000, 32'h00400014, 6'h0E, 5'd0, 5'd8,  5'd16, 5'd0,  6'h00, 32'h00008000, 26'h0088000, 32'h00220000};
    vecs[7] = '{32'h08000000, 32'hFFFFFFFC, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 32'h00000000, 26'h0000000, 32'h00000000};
    vecs[8] = '{32'h012A4020, 32'h00400020, 6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 32'h00004020, 26'h12A4020, 32'h04A90080};
    vecs[9] = '{32'h00008000, 32'h00400028, 6'h00, 5'd0, 5'd0,  5'd16, 5'd0,  6'h00, 32'hFFFF8000, 26'h0008000, 32'h00020000};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    #2;
    check_empty("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Decode table: each word goes into an empty queue, is checked, then popped.
    for (int i = 0; i < 10; i++) begin
      push_one(vecs[i].inst, vecs[i].pc);
      check($sformatf("v%0d out_valid", i),   64'(bus.out_valid),   64'd1);
      check($sformatf("v%0d count", i),       64'(count),           64'd1);
      check($sformatf("v%0d out_op", i),      64'(bus.out_op),      64'(vecs[i].op));
      check($sformatf("v%0d out_rs", i),      64'(bus.out_rs),      64'(vecs[i].rs));
      check($sformatf("v%0d out_rt", i),      64'(bus.out_rt),      64'(vecs[i].rt));
      check($sformatf("v%0d out_rd", i),      64'(bus.out_rd),      64'(vecs[i].rd));
      check($sformatf("v%0d out_shamt", i),   64'(bus.out_shamt),   64'(vecs[i].shamt));
      check($sformatf("v%0d out_func", i),    64'(bus.out_func),    64'(vecs[i].func));
      check($sformatf("v%0d out_imm16", i),   64'(bus.out_imm16),   64'(vecs[i].inst[15:0]));
      check($sformatf("v%0d out_imm_ext", i), 64'(bus.out_imm_ext), 64'(vecs[i].imm_ext));
      check($sformatf("v%0d out_target", i),  64'(bus.out_target),  64'(vecs[i].target));
      check($sformatf("v%0d out_jaddr", i),   64'(bus.out_jaddr),   64'(vecs[i].jaddr));
      check($sformatf("v%0d out_pc", i),      64'(bus.out_pc),      64'(vecs[i].pc));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_empty($sformatf("v%0d popped", i));
    end

    // Fill to DEPTH with decode stalled; pointers start at 2 so the drain wraps.
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1;
      bus.in_inst  = 32'h20080000 | 32'(i);
      bus.in_pc    = 32'h00001000 + 32'(4 * i);
      @(negedge clk);
    end
    bus.in_inst = 32'hDEAD0000;
    bus.in_pc   = 32'h00002000;
    check("full count",    64'(count),        64'd4);
    check("full in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fifth push ignored count", 64'(count),      64'd4);
    check("fifth push head pc",       64'(bus.out_pc), 64'h1000);
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d out_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("drain%0d out_pc", i),    64'(bus.out_pc),    64'(32'h1000 + 32'(4 * i)));
      check($sformatf("drain%0d out_imm16", i), 64'(bus.out_imm16), 64'(i));
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    check_empty("drained");

    // Push and pop together at count=2 keeps the count and advances the head.
    push_one(32'h20080011, 32'h00003000);
    push_one(32'h20080022, 32'h00003004);
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h20080033;
    bus.in_pc     = 32'h00003008;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("push+pop count",     64'(count),         64'd2);
    check("push+pop head pc",   64'(bus.out_pc),    64'h3004);
    check("push+pop head imm",  64'(bus.out_imm16), 64'h0022);

    // Flush wins over a simultaneous push and pop.
    bus.in_valid  = 1'b1;
    bus.in_inst   = 32'h20080044;
    bus.in_pc     = 32'h0000300C;
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
    check_empty("flush");
    @(negedge clk);
    check_empty("flush settled");

    // Asynchronous reset at count=3 clears before the next rising edge.
    push_one(32'h20080055, 32'h00004000);
    push_one(32'h20080066, 32'h00004004);
    push_one(32'h20080077, 32'h00004008);
    check("pre-reset count", 64'(count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check_empty("async reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_one(32'h3C08ABCD, 32'h00005000);
    check("post-reset count",   64'(count),           64'd1);
    check("post-reset pc",      64'(bus.out_pc),      64'h5000);
    check("post-reset imm_ext", 64'(bus.out_imm_ext), 64'hABCD0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_decode_queue.md
# inst_decode_queue

Parametrised instruction buffer between fetch and decode in the MIPS core. Holds up to DEPTH fetched words with their PCs under a valid/ready handshake, and presents the head entry already split into op/rs/rt/rd/shamt/func/imm16/target. It also presents the extended immediate and the absolute jump address. A synchronous flush discards all entries on branch/jump redirect.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 32, PC width; ≥28

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous discard of all entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept; = (count < DEPTH)
- in_inst  in  32  instruction word
- in_pc  in  PC_W  PC of in_inst
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  decode consumes head
- out_op  out  6  head[31:26]
- out_rs  out  5  head[25:21]
- out_rt  out  5  head[20:16]
- out_rd  out  5  head[15:11]
- out_shamt  out  5  head[10:6]
- out_func  out  6  head[5:0]
- out_imm16  out  16  head[15:0]
- out_imm_ext  out  32  extended immediate (see Operation)
- out_target  out  26  head[25:0]
- out_jaddr  out  PC_W  jump address
- out_pc  out  PC_W  head PC
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- Circular storage with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Push and pop in the same cycle:
  - Allowed when 0 < count < DEPTH; count unchanged.
  - When full, in_ready=0, so only the pop happens. There is no same-cycle pass-through.
  - When empty, out_valid=0, so only the push happens.
- flush has priority over push and pop in that cycle. Pointers and count go to 0, and the offered word is dropped (the fetcher must re-present it).
- Field outputs are combinational from the head entry (first-word fall-through). When out_valid=0, every field output, out_imm_ext, out_jaddr and out_pc is 0.
- out_imm_ext:
  - op 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend.
  - op 0x0F (lui): {imm16, 16'h0}.
  - All other ops: sign-extend.
- out_jaddr = {pc4[PC_W-1:28], target, 2'b00}, where pc4 = out_pc + 4 (truncated to PC_W). Computed for every head regardless of opcode.

## Timing
- Reset (async assert, sync-safe deassert): count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0. Storage contents are don't-care.
- Latency: word pushed at edge N appears on outputs after edge N; visible in cycle N+1 if the queue was empty.
- in_ready and out_valid depend only on registered count, never combinationally on in_valid or out_ready.
- Reset mid-operation clears immediately and asynchronously; in-flight handshakes are lost.
- flush is registered: outputs are empty the cycle after flush is sampled.

## Structure
- Shared package mips_pkg: opcode localparams OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_J, OP_JAL; field-width localparams.
- One natural sub-module, inst_field_split: purely combinational split of a 32-bit word plus immediate extension, reused by later decode stages. The queue instantiates it on the head entry.

## Test plan
- Reset then push 0x2008FFFF (addi) at pc 0x00400000 → next cycle out_valid=1, out_op=0x08, out_rt=8, out_imm_ext=0xFFFFFFFF, count=1.
- Push 0x3408FFFF (ori) → out_imm_ext=0x0000FFFF. Push 0x3C081234 (lui) → out_imm_ext=0x12340000.
- Push 0x08100004 (j) at pc 0x00400008 → out_target=0x0100004, out_jaddr=0x00400010.
- Fill DEPTH=4 with out_ready=0 → in_ready=0, count=4. A fifth push is ignored. Drain yields the 4 words in order through pointer wrap-around.
- At count=2, assert push, pop and flush together → next cycle count=0, out_valid=0, pushed word absent.
- Assert rst mid-stream at count=3 → count=0, out_valid=0 before the next clk edge.
